// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP RX frame controller.
//   rx_state_e : receive FSM states, one transition per valid byte
//   ERR_*      : values reported on err_code
//   HDR_BYTES  : bytes preceding the payload (HDR0, HDR1, CMD, LENH, LENL)
package udp_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr1,
        StCmd,
        StLenh,
        StLenl,
        StPayload,
        StDrop
    } rx_state_e;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_HDR      = 3'd1;
    localparam logic [2:0] ERR_BAD_CMD      = 3'd2;
    localparam logic [2:0] ERR_LEN_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TRUNC        = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW     = 3'd5;

    localparam int unsigned HDR_BYTES = 5;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter.
//   udp_clk : clock
//   rst_n   : asynchronous active-low reset, clears the count
//   clr     : synchronous clear
//   en      : count one event this cycle
//   cnt     : current count, sticks at 16'hFFFF
module sat_cnt16 (
    input  logic        udp_clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/udp_rx_frame_ctrl.sv
// Receive-side frame controller on the UDP application RX byte stream.
// Parses HDR0 HDR1 CMD LENH LENL + LEN payload bytes, steers the payload to the
// channel selected by CMD and reports one outcome pulse per packet.
//   udp_clk, rst_n          : clock, asynchronous active-low reset
//   app_rx_data_valid/_data : RX byte stream, one packet per contiguous valid run
//   app_rx_data_length      : UDP payload length, stable while valid is high
//   ch_ready                : per-sink accept flag, sampled with each payload byte
//   ch_wr_en/ch_wr_data     : one-hot payload write strobe and byte (registered)
//   ch_sel                  : channel of the current/last frame
//   frame_start/done/err    : one-cycle event pulses
//   err_code                : cause of the last rejected frame
//   frame_cnt/err_cnt       : saturating good/bad frame counters
module udp_rx_frame_ctrl
    import udp_rx_pkg::*;
#(
    parameter logic [7:0]  HDR0   = 8'h00,
    parameter logic [7:0]  HDR1   = 8'h00,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CHW    = 2
) (
    input  logic              udp_clk,
    input  logic              rst_n,
    input  logic              app_rx_data_valid,
    input  logic [7:0]        app_rx_data,
    input  logic [15:0]       app_rx_data_length,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_wr_en,
    output logic [7:0]        ch_wr_data,
    output logic [CHW-1:0]    ch_sel,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
);

    rx_state_e         state_q, state_d;
    logic [CHW-1:0]    ch_sel_q, ch_sel_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       rem_q, rem_d;
    logic [2:0]        err_q, err_d;        // first error of the frame in flight
    logic [NUM_CH-1:0] wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [2:0]        code_q, code_d;
    logic [16:0]       frame_len;

    // Declared payload length plus header, widened so LEN=FFFF cannot wrap.
    assign frame_len = {1'b0, len_hi_q, app_rx_data} + 17'(HDR_BYTES);

    always_comb begin
        logic [2:0] new_err;
        new_err   = ERR_NONE;
        state_d   = state_q;
        ch_sel_d  = ch_sel_q;
        len_hi_d  = len_hi_q;
        rem_d     = rem_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        code_d    = code_q;

        if (app_rx_data_valid) begin
            unique case (state_q)
                StIdle: begin
                    start_d = 1'b1;
                    if (app_rx_data == HDR0) begin
                        state_d = StHdr1;
                    end else begin
                        new_err = ERR_BAD_HDR;
                        state_d = StDrop;
                    end
                end
                StHdr1: begin
                    if (app_rx_data == HDR1) begin
                        state_d = StCmd;
                    end else begin
                        new_err = ERR_BAD_HDR;
                        state_d = StDrop;
                    end
                end
                StCmd: begin
                    ch_sel_d = app_rx_data[CHW-1:0];
                    if ((app_rx_data >> CHW) != 8'd0) begin
                        new_err = ERR_BAD_CMD;
                        state_d = StDrop;
                    end else begin
                        state_d = StLenh;
                    end
                end
                StLenh: begin
                    len_hi_d = app_rx_data;
                    state_d  = StLenl;
                end
                StLenl: begin
                    if (frame_len != {1'b0, app_rx_data_length}) begin
                        new_err = ERR_LEN_MISMATCH;
                        state_d = StDrop;
                    end else begin
                        rem_d   = {len_hi_q, app_rx_data};
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    if (rem_q == 16'd0) begin
                        new_err = ERR_LEN_MISMATCH;
                        state_d = StDrop;
                    end else begin
                        rem_d = rem_q - 16'd1;
                        // A busy sink loses the byte but the frame keeps counting down.
                        if (ch_ready[ch_sel_q]) begin
                            wr_en_d[ch_sel_q] = 1'b1;
                            wr_data_d         = app_rx_data;
                        end else begin
                            new_err = ERR_OVERFLOW;
                        end
                    end
                end
                StDrop: begin
                end
                default: state_d = StDrop;
            endcase
            if (err_q == ERR_NONE) begin
                err_d = new_err;
            end
        end else if (state_q != StIdle) begin
            state_d = StIdle;
            err_d   = ERR_NONE;
            rem_d   = '0;
            if (err_q != ERR_NONE) begin
                ferr_d = 1'b1;
                code_d = err_q;
            end else if ((state_q != StPayload) || (rem_q != 16'd0)) begin
                ferr_d = 1'b1;
                code_d = ERR_TRUNC;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_sel_q  <= '0;
            len_hi_q  <= '0;
            rem_q     <= '0;
            err_q     <= ERR_NONE;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            len_hi_q  <= len_hi_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            code_q    <= code_d;
        end
    end

    sat_cnt16 u_frame_cnt (
        .udp_clk (udp_clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .en      (done_d),
        .cnt     (frame_cnt)
    );

    sat_cnt16 u_err_cnt (
        .udp_clk (udp_clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .en      (ferr_d),
        .cnt     (err_cnt)
    );

    assign ch_wr_en    = wr_en_q;
    assign ch_wr_data  = wr_data_q;
    assign ch_sel      = ch_sel_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign frame_err   = ferr_q;
    assign err_code    = code_q;

endmodule
